vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vga_sync_gen
// Brief    : VGA raster counters and sync/blank timing, advanced by a pixel strobe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam logic [9:0] C_H_TOTAL  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [9:0] C_V_TOTAL  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [9:0] C_H_LAST   = C_H_TOTAL - 10'd1;
    localparam logic [9:0] C_V_LAST   = C_V_TOTAL - 10'd1;
    localparam logic [9:0] C_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] C_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] C_HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] C_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] C_VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] C_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_line_tick;
    logic       r_frame_tick;

    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_hs_active;
    logic       w_vs_active;
    logic       w_visible;

    always_comb begin
        w_x_wrap = (r_x == C_H_LAST);
        w_y_wrap = (r_y == C_V_LAST);
        w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? 10'd0 : r_y + 10'd1;
        end else begin
            w_y_next = r_y;
        end
        // Decode the upcoming position so the registered strobes line up with the counters.
        w_hs_active = (w_x_next >= C_HS_START) && (w_x_next <= C_HS_END);
        w_vs_active = (w_y_next >= C_VS_START) && (w_y_next <= C_VS_END);
        w_visible   = (w_x_next < C_H_VIS) && (w_y_next < C_V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video_on   <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (pix_en) begin
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_hsync      <= w_hs_active ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_vs_active ? SYNC_POL : ~SYNC_POL;
            r_video_on   <= w_visible;
            r_line_tick  <= w_x_wrap;
            r_frame_tick <= w_x_wrap && w_y_wrap;
        end else begin
            // Ticks are single-clock pulses; everything else holds between strobes.
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end
    end

    assign pixel_x    = r_x;
    assign pixel_y    = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign line_tick  = r_line_tick;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
